demod_ch_sched: RTL

Round-robin scheduler that time-shares one `demod` datapath between up to four independent 24-bit sample streams. Each input channel has a one-entry holding register. Held samples are granted in rotating order onto a single AXI-Stream master that feeds `demod`. `m_axis_tuser` carries the channel index, and a programmable minimum spacing between issued samples matches the demodulator's per-sample throughput.

---
 rtl/demod_ch_sched.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/demod_ch_sched.sv
// demod_ch_sched: round-robin scheduler sharing one demod datapath between
// up to four 24-bit sample streams. Each input channel has a one-entry
// holding register. Held samples are issued in rotating order onto a single
// AXI-Stream master, and consecutive issues are spaced by at least MIN_GAP
// cycles.
//
// Optional feature macro: DEMOD_SCHED_OVF_CNT_EN
//   defined   - per-channel 16-bit saturating overflow counters
//               (a cycle with tvalid high while the holding register is full)
//   undefined - ovf_cnt is tied to zero
//
// Ports
//   s_axis_aclk     clock
//   s_axis_aresetn  asynchronous active-low reset
//   s_axis_tdata    N_CH packed input samples, channel i at [i*DATA_W +: DATA_W]
//   s_axis_tvalid   per-channel input valid
//   s_axis_tready   per-channel input ready (holding register empty)
//   m_axis_tdata    issued sample
//   m_axis_tvalid   output register occupied
//   m_axis_tready   downstream ready
//   m_axis_tuser    channel index of the issued sample
//   ovf_cnt         N_CH packed 16-bit overflow counters
module demod_ch_sched #(
    parameter int unsigned DATA_W  = 24,
    parameter int unsigned N_CH    = 4,
    parameter int unsigned MIN_GAP = 21
) (
    input  logic                   s_axis_aclk,
    input  logic                   s_axis_aresetn,
    input  logic [N_CH*DATA_W-1:0] s_axis_tdata,
    input  logic [N_CH-1:0]        s_axis_tvalid,
    output logic [N_CH-1:0]        s_axis_tready,
    output logic [DATA_W-1:0]      m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [1:0]             m_axis_tuser,
    output logic [N_CH*16-1:0]     ovf_cnt
);

    localparam int unsigned IDX_W = 2;
    localparam int unsigned GAP_W = $clog2(MIN_GAP) + 1;
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(MIN_GAP - 1);
    // With a gap of one, a new sample may load on the same edge as the handshake.
    localparam bit BACK2BACK = (MIN_GAP == 1);

    logic [DATA_W-1:0] r_hold [N_CH];
    logic [N_CH-1:0]   r_full;
    logic [IDX_W-1:0]  r_last;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic              r_tvalid;
    logic [DATA_W-1:0] r_tdata;
    logic [IDX_W-1:0]  r_tuser;

    logic [N_CH-1:0]   w_capture;
    logic              w_hs;
    logic              w_found;
    logic              w_load;
    logic [IDX_W-1:0]  w_cand;
    logic [IDX_W-1:0]  w_grant_idx;
    logic [N_CH-1:0]   w_grant_oh;
    logic [N_CH-1:0]   w_full_nxt;
    logic [GAP_W-1:0]  w_gap_nxt;
    logic              w_tvalid_nxt;
    logic [DATA_W-1:0] w_tdata_nxt;
    logic [IDX_W-1:0]  w_tuser_nxt;
    logic [IDX_W-1:0]  w_last_nxt;

    assign s_axis_tready = ~r_full;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tuser  = r_tuser;

    // Next-state: arbitration, load decision, gap counter, output register.
    always_comb begin
        w_capture    = s_axis_tvalid & ~r_full;
        w_hs         = r_tvalid & m_axis_tready;
        w_found      = 1'b0;
        w_cand       = r_last;
        w_grant_idx  = r_last;

        // First full channel scanning upward from last+1, wrapping at N_CH.
        for (int unsigned k = 1; k <= N_CH; k++) begin
            w_cand = IDX_W'((32'(r_last) + k) % N_CH);
            if (!w_found && r_full[w_cand]) begin
                w_grant_idx = w_cand;
                w_found     = 1'b1;
            end
        end

        w_load       = w_found && (r_gap_cnt <= GAP_W'(1)) && (!r_tvalid || (BACK2BACK && w_hs));
        w_grant_oh   = w_load ? (N_CH'(1) << w_grant_idx) : '0;
        w_full_nxt   = (r_full | w_capture) & ~w_grant_oh;

        w_gap_nxt    = r_gap_cnt;
        if (w_hs) begin
            w_gap_nxt = GAP_RELOAD;
        end else if (r_gap_cnt != '0) begin
            w_gap_nxt = r_gap_cnt - GAP_W'(1);
        end

        w_tvalid_nxt = r_tvalid;
        w_tdata_nxt  = r_tdata;
        w_tuser_nxt  = r_tuser;
        w_last_nxt   = r_last;
        if (w_load) begin
            w_tvalid_nxt = 1'b1;
            w_tdata_nxt  = r_hold[w_grant_idx];
            w_tuser_nxt  = w_grant_idx;
            w_last_nxt   = w_grant_idx;
        end else if (w_hs) begin
            w_tvalid_nxt = 1'b0;
        end
    end

    // Control and output registers.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            r_full    <= '0;
            r_last    <= IDX_W'(N_CH - 1);
            r_gap_cnt <= '0;
            r_tvalid  <= 1'b0;
            r_tdata   <= '0;
            r_tuser   <= '0;
        end else begin
            r_full    <= w_full_nxt;
            r_last    <= w_last_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_tvalid  <= w_tvalid_nxt;
            r_tdata   <= w_tdata_nxt;
            r_tuser   <= w_tuser_nxt;
        end
    end

    // Per-channel holding registers.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            for (int i = 0; i < N_CH; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (w_capture[i]) begin
                    r_hold[i] <= s_axis_tdata[i*DATA_W +: DATA_W];
                end
            end
        end
    end

`ifdef DEMOD_SCHED_OVF_CNT_EN
    logic [15:0] r_ovf [N_CH];

    // A sample offered while the holding register is still full counts once per cycle.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            for (int i = 0; i < N_CH; i++) begin
                r_ovf[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (s_axis_tvalid[i] && r_full[i] && (r_ovf[i] != 16'hFFFF)) begin
                    r_ovf[i] <= r_ovf[i] + 16'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ovf
        assign ovf_cnt[g*16 +: 16] = r_ovf[g];
    end
`else
    assign ovf_cnt = '0;
`endif

endmodule
